turn_controller: RTL and testbench
==================================

Name: turn_controller

Overview:
- Sequences one chess move per turn on the board-state block.
- Accepts registered mouse clicks (square index) and checks that the clicked piece belongs to the side to move.
- Requests legal moves from the move generator and drives the board's pick/place pulses and square address.
- Validates the target click, toggles the turn, counts moves and detects king capture (game over).
- Sits between the mouse/click decoder, the move generator and the board-state register file.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles to wait for movegen_done before aborting the selection.
- MC_WIDTH, 10: width of the saturating move counter.

Ports:
- clk  in  1  system clock, single domain
- rst  in  1  synchronous, active-high reset
- click  in  1  one-cycle pulse: square selected by mouse
- click_pos  in  6  clicked square, [5:3] row, [2:0] column
- sq_code  in  4  board piece code at click_pos, valid in the same cycle as click. Codes: 0 empty; 1-6 white; 7-C black; 6 = white king, C = black king.
- movegen_done  in  1  one-cycle pulse: movegen_moves valid
- movegen_moves  in  64  legal target mask, square p at bit [63-p]
- movegen_req  out  1  one-cycle request to move generator
- movegen_src  out  6  source square for the request
- pick_piece  out  1  one-cycle pulse to board: lift piece at figure_position
- place_piece  out  1  one-cycle pulse to board: drop held piece at figure_position
- figure_position  out  6  square address for pick/place
- highlight_moves  out  64  latched legal mask while a piece is held, else 0
- turn  out  1  0 white to move, 1 black to move
- move_count  out  MC_WIDTH  completed moves, saturating
- game_over  out  1  sticky: a king was captured
- winner  out  1  valid when game_over: 0 white, 1 black
- timeout_err  out  1  one-cycle pulse on move-generator timeout

Behaviour:
- Reset values (synchronous rst): state IDLE.
  - turn=0, move_count=0, game_over=0, winner=0.
  - All pulses 0, figure_position=0, movegen_src=0, highlight_moves=0.
  - Internal src, dst, moves and timeout counter cleared.
  - rst mid-move returns to IDLE with no pick/place issued. Board reset is done separately by the same rst.
- All outputs are registered. Pick/place pulses are high exactly in the PICK/PLACE state cycle.
- Own piece: (turn=0 and sq_code in 1..6) or (turn=1 and sq_code in 7..C).
- IDLE:
  - click with own piece: latch src=click_pos, go to REQ.
  - Empty, opponent or invalid code (D-F): ignore.
- REQ: movegen_req=1 and movegen_src=src for one cycle, clear timeout counter, go to WAIT_MV.
- WAIT_MV:
  - movegen_done: latch moves=movegen_moves. If moves==0, go to IDLE (piece not lifted); else go to PICK.
  - No done within TIMEOUT_CYCLES cycles: timeout_err pulse, go to IDLE.
  - done and timeout in the same cycle: done wins.
  - Clicks are ignored.
- PICK: pick_piece=1, figure_position=src, go to HOLD.
- HOLD: highlight_moves=moves; otherwise highlight_moves=0.
  - click_pos==src: cancel. dst=src, go to PLACE; turn and count unchanged.
  - moves[63-click_pos]==1: dst=click_pos, latch cap=sq_code, go to PLACE.
  - Any other click: ignored, stay in HOLD.
- PLACE: place_piece=1, figure_position=dst.
  - If dst!=src: turn toggles, move_count+1 (holds at 2^MC_WIDTH-1).
  - If dst!=src and cap is 6 or C: game_over=1, winner=mover, go to OVER; else go to IDLE.
- OVER: no further requests, pulses or turn changes; only rst exits.
- Latency:
  - click in IDLE at cycle n gives movegen_req at n+1.
  - movegen_done at cycle m gives pick_piece at m+1.
  - click in HOLD at cycle k gives place_piece at k+1.
- click in a state not listed above is dropped, never queued.

Test Plan:
- Reset, click square 52 (code 1, white pawn) -> movegen_req at +1 with movegen_src=52. Return done with bits for squares 44 and 36 set -> pick_piece at +1 with figure_position=52; highlight_moves=that mask in HOLD.
- From HOLD, click 44 -> place_piece at +1 with figure_position=44; turn=1, move_count=1, highlight_moves=0.
- turn=0, click square 1 (code 9, black) and square 20 (code 0) -> no movegen_req, state stays IDLE.
- In HOLD, click illegal square 30 -> nothing. Then click src 52 -> place_piece at 52; turn and move_count unchanged.
- No movegen_done for TIMEOUT_CYCLES -> timeout_err pulse, IDLE, pick_piece never asserted. Also: done with all-zero mask -> IDLE without pick.
- White captures on a square with sq_code=C -> game_over=1, winner=0. Later clicks produce no outputs until rst; rst asserted in HOLD -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/turn_controller_if.sv
// Bundle of click, move-generator and board signals around the turn controller.
// The controller takes the slave side; the click decoder, move generator and board take the master side.
interface turn_controller_if #(
    parameter int MC_WIDTH = 10
);
    logic                click;
    logic [5:0]          click_pos;
    logic [3:0]          sq_code;
    logic                movegen_done;
    logic [63:0]         movegen_moves;
    logic                movegen_req;
    logic [5:0]          movegen_src;
    logic                pick_piece;
    logic                place_piece;
    logic [5:0]          figure_position;
    logic [63:0]         highlight_moves;
    logic                turn;
    logic [MC_WIDTH-1:0] move_count;
    logic                game_over;
    logic                winner;
    logic                timeout_err;

    modport master (
        output click, click_pos, sq_code, movegen_done, movegen_moves,
        input  movegen_req, movegen_src, pick_piece, place_piece, figure_position,
               highlight_moves, turn, move_count, game_over, winner, timeout_err
    );

    modport slave (
        input  click, click_pos, sq_code, movegen_done, movegen_moves,
        output movegen_req, movegen_src, pick_piece, place_piece, figure_position,
               highlight_moves, turn, move_count, game_over, winner, timeout_err
    );
endinterface

// File: rtl/turn_controller.sv
// Sequences one chess move per turn: select own piece, fetch legal moves, pick, place, toggle turn.
// state   | meaning
// IDLE    | waiting for a click on a piece of the side to move
// REQ     | one-cycle request to the move generator
// WAIT_MV | waiting for movegen_done, bounded by TIMEOUT_CYCLES
// PICK    | one-cycle pick pulse at the source square
// HOLD    | piece held, legal targets highlighted, waiting for target click
// PLACE   | one-cycle place pulse at the destination, turn/count update
// OVER    | a king was captured; only reset leaves
module turn_controller #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MC_WIDTH       = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    turn_controller_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT_MV, S_PICK, S_HOLD, S_PLACE, S_OVER
    } state_t;

    state_t              r_state, w_state_n;
    logic [5:0]          r_src, w_src_n;
    logic [5:0]          r_dst, w_dst_n;
    logic [3:0]          r_cap, w_cap_n;
    logic [63:0]         r_moves, w_moves_n;
    logic [TW-1:0]       r_tmo, w_tmo_n;
    logic                r_req, w_req_n;
    logic [5:0]          r_mgsrc, w_mgsrc_n;
    logic                r_pick, w_pick_n;
    logic                r_place, w_place_n;
    logic [5:0]          r_fig, w_fig_n;
    logic [63:0]         r_hl, w_hl_n;
    logic                r_turn, w_turn_n;
    logic [MC_WIDTH-1:0] r_cnt, w_cnt_n;
    logic                r_go, w_go_n;
    logic                r_win, w_win_n;
    logic                r_terr, w_terr_n;
    logic                w_own;

    assign w_own = (!r_turn && bus.sq_code >= 4'd1 && bus.sq_code <= 4'd6) ||
                   ( r_turn && bus.sq_code >= 4'd7 && bus.sq_code <= 4'hC);

    always_comb begin
        w_state_n = r_state;
        w_src_n   = r_src;
        w_dst_n   = r_dst;
        w_cap_n   = r_cap;
        w_moves_n = r_moves;
        w_tmo_n   = r_tmo;
        w_turn_n  = r_turn;
        w_cnt_n   = r_cnt;
        w_go_n    = r_go;
        w_win_n   = r_win;
        w_terr_n  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.click && w_own) begin
                    w_src_n   = bus.click_pos;
                    w_state_n = S_REQ;
                end
            end
            S_REQ: begin
                w_tmo_n   = '0;
                w_state_n = S_WAIT_MV;
            end
            S_WAIT_MV: begin
                // done is checked first so it wins over a same-cycle timeout
                if (bus.movegen_done) begin
                    w_moves_n = bus.movegen_moves;
                    w_state_n = (|bus.movegen_moves) ? S_PICK : S_IDLE;
                end else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_terr_n  = 1'b1;
                    w_state_n = S_IDLE;
                end else begin
                    w_tmo_n = r_tmo + 1'b1;
                end
            end
            S_PICK: begin
                w_state_n = S_HOLD;
            end
            S_HOLD: begin
                if (bus.click) begin
                    if (bus.click_pos == r_src) begin
                        w_dst_n   = r_src;
                        w_cap_n   = 4'd0;
                        w_state_n = S_PLACE;
                    end else if (r_moves[~bus.click_pos]) begin
                        w_dst_n   = bus.click_pos;
                        w_cap_n   = bus.sq_code;
                        w_state_n = S_PLACE;
                    end
                end
            end
            S_PLACE: begin
                w_state_n = S_IDLE;
                if (r_dst != r_src) begin
                    w_turn_n = ~r_turn;
                    w_cnt_n  = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
                    if (r_cap == 4'd6 || r_cap == 4'hC) begin
                        w_go_n    = 1'b1;
                        w_win_n   = r_turn;
                        w_state_n = S_OVER;
                    end
                end
            end
            S_OVER: begin
                w_state_n = S_OVER;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so pulses line up with their state cycle
        w_req_n   = (w_state_n == S_REQ);
        w_pick_n  = (w_state_n == S_PICK);
        w_place_n = (w_state_n == S_PLACE);
        w_mgsrc_n = (w_state_n == S_REQ) ? w_src_n : r_mgsrc;
        w_fig_n   = r_fig;
        if (w_state_n == S_PICK) begin
            w_fig_n = w_src_n;
        end else if (w_state_n == S_PLACE) begin
            w_fig_n = w_dst_n;
        end
        w_hl_n = (w_state_n == S_HOLD) ? w_moves_n : 64'd0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_cap   <= '0;
            r_moves <= '0;
            r_tmo   <= '0;
            r_req   <= 1'b0;
            r_mgsrc <= '0;
            r_pick  <= 1'b0;
            r_place <= 1'b0;
            r_fig   <= '0;
            r_hl    <= '0;
            r_turn  <= 1'b0;
            r_cnt   <= '0;
            r_go    <= 1'b0;
            r_win   <= 1'b0;
            r_terr  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_src   <= w_src_n;
            r_dst   <= w_dst_n;
            r_cap   <= w_cap_n;
            r_moves <= w_moves_n;
            r_tmo   <= w_tmo_n;
            r_req   <= w_req_n;
            r_mgsrc <= w_mgsrc_n;
            r_pick  <= w_pick_n;
            r_place <= w_place_n;
            r_fig   <= w_fig_n;
            r_hl    <= w_hl_n;
            r_turn  <= w_turn_n;
            r_cnt   <= w_cnt_n;
            r_go    <= w_go_n;
            r_win   <= w_win_n;
            r_terr  <= w_terr_n;
        end
    end

    assign bus.movegen_req     = r_req;
    assign bus.movegen_src     = r_mgsrc;
    assign bus.pick_piece      = r_pick;
    assign bus.place_piece     = r_place;
    assign bus.figure_position = r_fig;
    assign bus.highlight_moves = r_hl;
    assign bus.turn            = r_turn;
    assign bus.move_count      = r_cnt;
    assign bus.game_over       = r_go;
    assign bus.winner          = r_win;
    assign bus.timeout_err     = r_terr;
endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller: expected pulses go into a scoreboard queue,
// a negedge monitor pops and compares every req/pick/place/timeout pulse.
module tb_turn_controller;
    localparam int TMO = 1024;
    localparam int MCW = 10;
    localparam int K_REQ = 0, K_PICK = 1, K_PLACE = 2, K_TMO = 3, K_NONE = -1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    turn_controller_if #(.MC_WIDTH(MCW)) bus ();

    turn_controller #(.TIMEOUT_CYCLES(TMO), .MC_WIDTH(MCW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        int kind;
        int pos;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  cyc   = 0;
    int  n_cmp = 0;
    int  n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] sqbit(input int p);
        logic [63:0] one;
        one = 64'd1;
        return one << (63 - p);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon_pulse(input int kind, input logic p, input int pos);
        if (p) begin
            n_cmp++;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].kind == kind) begin
                if (pos != exp_q[0].pos) begin
                    n_err++;
                    $display("FAIL pulse_kind%0d_pos: got %0d want %0d (cycle %0d)",
                             kind, pos, exp_q[0].pos, cyc);
                end
                void'(exp_q.pop_front());
            end else begin
                n_err++;
                $display("FAIL unexpected_kind%0d: got pulse at cycle %0d pos %0d want none",
                         kind, cyc, pos);
            end
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            n_cmp++;
            n_err++;
            $display("FAIL missing_kind%0d: got no pulse want one at cycle %0d pos %0d",
                     exp_q[0].kind, exp_q[0].cyc, exp_q[0].pos);
            void'(exp_q.pop_front());
        end
        mon_pulse(K_REQ,   bus.movegen_req, int'(bus.movegen_src));
        mon_pulse(K_PICK,  bus.pick_piece,  int'(bus.figure_position));
        mon_pulse(K_PLACE, bus.place_piece, int'(bus.figure_position));
        mon_pulse(K_TMO,   bus.timeout_err, 0);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle click; if kind is given, the matching pulse is expected on the next cycle
    task automatic click(input int pos, input int code, input int kind, input int epos);
        bus.click     = 1'b1;
        bus.click_pos = 6'(pos);
        bus.sq_code   = 4'(code);
        if (kind != K_NONE) exp_q.push_back('{kind: kind, pos: epos, cyc: cyc + 1});
        @(negedge clk);
        bus.click     = 1'b0;
        bus.click_pos = '0;
        bus.sq_code   = '0;
    endtask

    task automatic mg_done(input logic [63:0] m, input int src);
        bus.movegen_done  = 1'b1;
        bus.movegen_moves = m;
        if (m != 64'd0) exp_q.push_back('{kind: K_PICK, pos: src, cyc: cyc + 1});
        @(negedge clk);
        bus.movegen_done  = 1'b0;
        bus.movegen_moves = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_turn"},  64'(bus.turn), 64'd0);
        chk({tag, "_count"}, 64'(bus.move_count), 64'd0);
        chk({tag, "_gover"}, 64'(bus.game_over), 64'd0);
        chk({tag, "_winner"}, 64'(bus.winner), 64'd0);
        chk({tag, "_hl"},    bus.highlight_moves, 64'd0);
        chk({tag, "_fig"},   64'(bus.figure_position), 64'd0);
        chk({tag, "_mgsrc"}, 64'(bus.movegen_src), 64'd0);
        chk({tag, "_pulses"},
            64'({bus.movegen_req, bus.pick_piece, bus.place_piece, bus.timeout_err}), 64'd0);
    endtask

    initial begin
        int c;
        logic [63:0] m;
        bus.click = 1'b0;
        bus.click_pos = '0;
        bus.sq_code = '0;
        bus.movegen_done = 1'b0;
        bus.movegen_moves = '0;
        rst = 1'b1;
        tick(3);
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick(1);

        // White to move: black piece, empty square and invalid code are ignored
        click(1, 9, K_NONE, 0);
        click(20, 0, K_NONE, 0);
        click(5, 13, K_NONE, 0);
        tick(2);

        // White pawn 52 -> 44
        m = sqbit(44) | sqbit(36);
        click(52, 1, K_REQ, 52);
        tick(1);
        mg_done(m, 52);
        tick(1);
        chk("hold_hl_52", bus.highlight_moves, m);
        click(44, 0, K_PLACE, 44);
        tick(1);
        chk("mv1_turn", 64'(bus.turn), 64'd1);
        chk("mv1_count", 64'(bus.move_count), 64'd1);
        chk("mv1_hl", bus.highlight_moves, 64'd0);

        // Black selects 12, illegal click ignored, then cancel on the source square
        m = sqbit(20) | sqbit(28);
        click(12, 7, K_REQ, 12);
        tick(1);
        mg_done(m, 12);
        tick(1);
        click(30, 0, K_NONE, 0);
        chk("hold_after_illegal_hl", bus.highlight_moves, m);
        click(12, 7, K_PLACE, 12);
        tick(1);
        chk("cancel_turn", 64'(bus.turn), 64'd1);
        chk("cancel_count", 64'(bus.move_count), 64'd1);

        // Black 12 -> 20
        click(12, 7, K_REQ, 12);
        tick(1);
        mg_done(sqbit(20), 12);
        tick(1);
        click(20, 0, K_PLACE, 20);
        tick(1);
        chk("mv2_turn", 64'(bus.turn), 64'd0);
        chk("mv2_count", 64'(bus.move_count), 64'd2);

        // Move generator never answers: timeout TMO cycles into WAIT_MV, clicks ignored meanwhile
        c = cyc;
        click(51, 1, K_REQ, 51);
        exp_q.push_back('{kind: K_TMO, pos: 0, cyc: c + TMO + 2});
        tick(2);
        click(52, 1, K_NONE, 0);
        tick(TMO + 3);
        chk("tmo_count", 64'(bus.move_count), 64'd2);

        // Empty legal mask: back to IDLE without lifting
        click(50, 1, K_REQ, 50);
        tick(1);
        mg_done(64'd0, 50);
        tick(2);
        chk("zero_mask_hl", bus.highlight_moves, 64'd0);

        // done on the last allowed WAIT_MV cycle wins over timeout; 49 -> 41
        c = cyc;
        click(49, 1, K_REQ, 49);
        tick(TMO);
        mg_done(sqbit(41), 49);
        tick(1);
        click(41, 0, K_PLACE, 41);
        tick(1);
        chk("mv3_turn", 64'(bus.turn), 64'd1);
        chk("mv3_count", 64'(bus.move_count), 64'd3);

        // Black 8 -> 16
        click(8, 7, K_REQ, 8);
        tick(1);
        mg_done(sqbit(16), 8);
        tick(1);
        click(16, 0, K_PLACE, 16);
        tick(1);
        chk("mv4_turn", 64'(bus.turn), 64'd0);

        // White 33 captures the black king on 4
        click(33, 3, K_REQ, 33);
        tick(1);
        mg_done(sqbit(4) | sqbit(25), 33);
        tick(1);
        click(4, 12, K_PLACE, 4);
        tick(1);
        chk("cap_gover", 64'(bus.game_over), 64'd1);
        chk("cap_winner", 64'(bus.winner), 64'd0);
        chk("cap_count", 64'(bus.move_count), 64'd5);

        // Game over: clicks from either side produce nothing
        click(10, 7, K_NONE, 0);
        click(40, 1, K_NONE, 0);
        tick(3);
        chk("over_sticky", 64'(bus.game_over), 64'd1);

        // Reset while a piece is held
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst_gover_clear", 64'(bus.game_over), 64'd0);
        click(52, 1, K_REQ, 52);
        tick(1);
        mg_done(sqbit(44), 52);
        tick(1);
        chk("hold2_hl", bus.highlight_moves, sqbit(44));
        rst = 1'b1;
        tick(1);
        chk_reset_outputs("rst_hold");
        rst = 1'b0;
        tick(5);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
